i2c_codec_cfg_responder: RTL and testbench

- I2C target (responder) that models the write-only control port of the WM8731-class audio codec. It is the far end of the I2C initiator in the NIOS audio system.
- Receives 2-byte register writes on scl/sda, ACKs them, and holds a shadow copy of registers R0..R9.
- Publishes every accepted write to the bench and host logic, so the NIOS configuration sequence can be checked in simulation or on-chip.

---
 rtl/i2c_codec_cfg_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_codec_cfg_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_cfg_responder.sv
`default_nettype none
// ============================================================================
// Module      : i2c_codec_cfg_responder
// Description : I2C target modelling the write-only control port of a
//               WM8731-class codec. Accepts 2-byte register writes, keeps a
//               shadow copy of R0..R9 and reports every committed write.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_codec_cfg_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         FILT_LEN = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr_valid,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    input  logic [3:0] cfg_rd_addr,
    output logic [8:0] cfg_rd_data,
    output logic       codec_active,
    output logic       bus_busy,
    output logic       nack_pulse
);

    localparam logic [3:0] c_filt_max = 4'(FILT_LEN - 1);
    localparam logic [8:0] c_def [0:9] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                           9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_ADDR        = 4'd1,
        S_ACK_A       = 4'd2,
        S_BYTE1       = 4'd3,
        S_ACK_1       = 4'd4,
        S_BYTE2       = 4'd5,
        S_ACK_2       = 4'd6,
        S_COMMIT_WAIT = 4'd7,
        S_IGNORE      = 4'd8
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through conditioning.
    logic [1:0] w_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_filt;
    logic [1:0] r_filt_d;
    logic [3:0] r_fcnt [2];

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    state_t     r_state;
    state_t     w_next;
    logic       w_shift_en;
    logic       w_clr_cnt;
    logic       w_nack;
    logic       w_commit;
    logic       w_latch1;
    logic       w_latch2;

    logic [7:0] r_shift;
    logic [3:0] r_bitcnt;
    logic [7:0] r_byte1;
    logic [7:0] r_byte2;
    logic [8:0] r_shadow [0:9];

    assign w_raw = {sda_in, scl_in};

    // Two-flop synchroniser followed by a run-length filter per line; the
    // filtered level only follows the input after FILT_LEN equal samples.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            r_fcnt[0] <= 4'd0;
            r_fcnt[1] <= 4'd0;
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_filt[k]) begin
                    r_fcnt[k] <= 4'd0;
                end else if (r_fcnt[k] == c_filt_max) begin
                    r_filt[k] <= r_sync2[k];
                    r_fcnt[k] <= 4'd0;
                end else begin
                    r_fcnt[k] <= r_fcnt[k] + 4'd1;
                end
            end
        end
    end

    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
    assign w_start    = r_filt[0] & r_filt_d[0] & r_filt_d[1] & ~r_filt[1];
    assign w_stop     = r_filt[0] & r_filt_d[0] & ~r_filt_d[1] & r_filt[1];

    // Protocol state register.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    // Next-state and control decode; STOP and START override every state.
    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_clr_cnt  = 1'b0;
        w_nack     = 1'b0;
        w_commit   = 1'b0;
        w_latch1   = 1'b0;
        w_latch2   = 1'b0;
        if (w_stop) begin
            w_next = S_IDLE;
        end else if (w_start) begin
            w_next    = S_ADDR;
            w_clr_cnt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ADDR, S_BYTE1, S_BYTE2, S_COMMIT_WAIT: begin
                    if (w_scl_rise && r_bitcnt != 4'd8) begin
                        w_shift_en = 1'b1;
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        case (r_state)
                            S_ADDR: begin
                                if (r_shift[7:1] == DEV_ADDR) begin
                                    if (!r_shift[0]) begin
                                        w_next = S_ACK_A;
                                    end else begin
                                        w_nack = 1'b1;
                                        w_next = S_IGNORE;
                                    end
                                end else begin
                                    // Foreign address: stay silent.
                                    w_next = S_IGNORE;
                                end
                            end
                            S_BYTE1: begin
                                w_latch1 = 1'b1;
                                w_next   = S_ACK_1;
                            end
                            S_BYTE2: begin
                                w_latch2 = 1'b1;
                                w_next   = S_ACK_2;
                            end
                            default: begin
                                w_nack = 1'b1;
                                w_next = S_IGNORE;
                            end
                        endcase
                    end
                end
                S_ACK_A: begin
                    if (w_scl_fall) begin
                        w_next    = S_BYTE1;
                        w_clr_cnt = 1'b1;
                    end
                end
                S_ACK_1: begin
                    if (w_scl_fall) begin
                        w_next    = S_BYTE2;
                        w_clr_cnt = 1'b1;
                    end
                end
                S_ACK_2: begin
                    if (w_scl_fall) begin
                        w_next    = S_COMMIT_WAIT;
                        w_clr_cnt = 1'b1;
                        w_commit  = 1'b1;
                    end
                end
                S_IGNORE: ;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Byte shifter, bit counter, captured bytes and the write/NACK strobes.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_shift      <= 8'd0;
            r_bitcnt     <= 4'd0;
            r_byte1      <= 8'd0;
            r_byte2      <= 8'd0;
            nack_pulse   <= 1'b0;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= 7'd0;
            reg_wr_data  <= 9'd0;
        end else begin
            nack_pulse   <= w_nack;
            reg_wr_valid <= w_commit;
            if (w_clr_cnt) begin
                r_bitcnt <= 4'd0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_shift  <= {r_shift[6:0], r_filt[1]};
            end
            if (w_latch1) r_byte1 <= r_shift;
            if (w_latch2) r_byte2 <= r_shift;
            if (w_commit) begin
                reg_wr_addr <= r_byte1[7:1];
                reg_wr_data <= {r_byte1[0], r_byte2};
            end
        end
    end

    // Shadow register file; address 15 restores the power-on defaults.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < 10; i++) r_shadow[i] <= c_def[i];
        end else if (w_commit) begin
            if (r_byte1[7:1] < 7'd10) begin
                r_shadow[r_byte1[4:1]] <= {r_byte1[0], r_byte2};
            end else if (r_byte1[7:1] == 7'd15) begin
                for (int i = 0; i < 10; i++) r_shadow[i] <= c_def[i];
            end
        end
    end

    assign cfg_rd_data  = (cfg_rd_addr < 4'd10) ? r_shadow[cfg_rd_addr] : 9'd0;
    assign codec_active = r_shadow[9][0];
    assign bus_busy     = (r_state != S_IDLE);
    // ACK drive is cut the moment a bus condition is seen.
    assign sda_oe = ((r_state == S_ACK_A) || (r_state == S_ACK_1) || (r_state == S_ACK_2))
                    && !w_start && !w_stop;

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_cfg_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_codec_cfg_responder
// Description : Directed self-checking bench for i2c_codec_cfg_responder,
//               acting as the I2C initiator with an open-drain SDA model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_codec_cfg_responder;

    localparam int Q = 200;  // quarter SCL period in ns (20 clocks)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       reg_wr_valid;
    logic [6:0] reg_wr_addr;
    logic [8:0] reg_wr_data;
    logic [3:0] cfg_rd_addr = 4'd0;
    logic [8:0] cfg_rd_data;
    logic       codec_active;
    logic       bus_busy;
    logic       nack_pulse;

    int n_vec = 0;
    int n_err = 0;
    int n_commit = 0;
    int n_nack = 0;
    int n_busy = 0;
    logic [6:0] last_addr = 7'd0;
    logic [8:0] last_data = 9'd0;

    logic [8:0] exp_def [0:9] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                  9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

    assign sda_line = sda_m & ~sda_oe;

    i2c_codec_cfg_responder #(.DEV_ADDR(7'h1A), .FILT_LEN(4)) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .scl_in       (scl_m),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .cfg_rd_addr  (cfg_rd_addr),
        .cfg_rd_data  (cfg_rd_data),
        .codec_active (codec_active),
        .bus_busy     (bus_busy),
        .nack_pulse   (nack_pulse)
    );

    always #5 clk = ~clk;

    // Strobe and activity monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (reg_wr_valid) begin
            n_commit  = n_commit + 1;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (nack_pulse) n_nack = n_nack + 1;
        if (bus_busy)   n_busy = n_busy + 1;
    end

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
        #Q;
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; #Q;
            scl_m = 1'b1; #(2*Q);
            scl_m = 1'b0; #Q;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        send_bits(b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        acked = sda_oe;
        #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic test_reset();
        #3;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #50;
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_vec++; if (reg_wr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", reg_wr_valid); end
        n_vec++; if (reg_wr_addr !== 7'd0 || reg_wr_data !== 9'd0) begin n_err++; $display("FAIL reset_wr_regs: got %h/%h want 00/000", reg_wr_addr, reg_wr_data); end
        n_vec++; if (bus_busy !== 1'b0 || codec_active !== 1'b0 || nack_pulse !== 1'b0) begin n_err++; $display("FAIL reset_flags: got busy=%b act=%b nack=%b want 0", bus_busy, codec_active, nack_pulse); end
        for (int i = 0; i < 16; i++) begin
            cfg_rd_addr = 4'(i); #1;
            n_vec++;
            if (cfg_rd_data !== ((i < 10) ? exp_def[i] : 9'd0)) begin
                n_err++; $display("FAIL reset_shadow[%0d]: got %h want %h", i, cfg_rd_data, (i < 10) ? exp_def[i] : 9'd0);
            end
        end
        #9;
    endtask

    task automatic test_write_r4();
        logic a0, a1, a2;
        int c0;
        c0 = n_commit;
        i2c_start();
        n_vec++; if (bus_busy !== 1'b1) begin n_err++; $display("FAIL r4_busy: got %b want 1", bus_busy); end
        send_byte(8'h34, a0);
        send_byte(8'h08, a1);
        send_byte(8'h12, a2);
        i2c_stop();
        n_vec++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL r4_acks: got %b want 111", {a0, a1, a2}); end
        n_vec++; if (n_commit - c0 !== 1) begin n_err++; $display("FAIL r4_commits: got %0d want 1", n_commit - c0); end
        n_vec++; if (last_addr !== 7'h04 || last_data !== 9'h012) begin n_err++; $display("FAIL r4_commit_val: got %h/%h want 04/012", last_addr, last_data); end
        cfg_rd_addr = 4'd4; #1;
        n_vec++; if (cfg_rd_data !== 9'h012) begin n_err++; $display("FAIL r4_shadow: got %h want 012", cfg_rd_data); end
        n_vec++; if (bus_busy !== 1'b0) begin n_err++; $display("FAIL r4_idle: got %b want 0", bus_busy); end
        #9;
    endtask

    task automatic test_codec_reset();
        logic a;
        i2c_start(); send_byte(8'h34, a); send_byte(8'h12, a); send_byte(8'h01, a); i2c_stop();
        n_vec++; if (codec_active !== 1'b1) begin n_err++; $display("FAIL r9_active: got %b want 1", codec_active); end
        i2c_start(); send_byte(8'h34, a); send_byte(8'h1E, a); send_byte(8'h00, a); i2c_stop();
        n_vec++; if (last_addr !== 7'h0F || last_data !== 9'h000) begin n_err++; $display("FAIL r15_commit_val: got %h/%h want 0f/000", last_addr, last_data); end
        n_vec++; if (codec_active !== 1'b0) begin n_err++; $display("FAIL r15_active: got %b want 0", codec_active); end
        for (int i = 0; i < 10; i++) begin
            cfg_rd_addr = 4'(i); #1;
            n_vec++;
            if (cfg_rd_data !== exp_def[i]) begin n_err++; $display("FAIL r15_shadow[%0d]: got %h want %h", i, cfg_rd_data, exp_def[i]); end
        end
        #9;
    endtask

    task automatic test_addr_filter();
        logic a36, a35;
        int c0, k0;
        c0 = n_commit; k0 = n_nack;
        i2c_start(); send_byte(8'h36, a36); i2c_stop();
        n_vec++; if (a36 !== 1'b0) begin n_err++; $display("FAIL foreign_ack: got %b want 0", a36); end
        n_vec++; if (n_nack - k0 !== 0) begin n_err++; $display("FAIL foreign_nack: got %0d want 0", n_nack - k0); end
        i2c_start(); send_byte(8'h35, a35); i2c_stop();
        n_vec++; if (a35 !== 1'b0) begin n_err++; $display("FAIL read_ack: got %b want 0", a35); end
        n_vec++; if (n_nack - k0 !== 1) begin n_err++; $display("FAIL read_nack: got %0d want 1", n_nack - k0); end
        n_vec++; if (n_commit - c0 !== 0) begin n_err++; $display("FAIL addr_commits: got %0d want 0", n_commit - c0); end
    endtask

    task automatic test_abort();
        logic a0, a1, a2;
        int c0;
        c0 = n_commit;
        i2c_start(); send_byte(8'h34, a0); send_byte(8'h08, a1); i2c_stop();
        n_vec++; if ({a0, a1} !== 2'b11) begin n_err++; $display("FAIL abort_acks: got %b want 11", {a0, a1}); end
        n_vec++; if (n_commit - c0 !== 0 || bus_busy !== 1'b0) begin n_err++; $display("FAIL abort_stop: got commits=%0d busy=%b want 0/0", n_commit - c0, bus_busy); end
        i2c_start(); send_byte(8'h34, a0); send_byte(8'h04, a1);
        i2c_start(); send_byte(8'h34, a0); send_byte(8'h04, a1); send_byte(8'h5A, a2); i2c_stop();
        n_vec++; if (n_commit - c0 !== 1) begin n_err++; $display("FAIL rstart_commits: got %0d want 1", n_commit - c0); end
        n_vec++; if (last_addr !== 7'h02 || last_data !== 9'h05A) begin n_err++; $display("FAIL rstart_commit_val: got %h/%h want 02/05a", last_addr, last_data); end
    endtask

    task automatic test_extra_byte();
        logic a0, a1, a2, a3;
        int c0, k0;
        c0 = n_commit; k0 = n_nack;
        i2c_start(); send_byte(8'h34, a0); send_byte(8'h0C, a1); send_byte(8'h7F, a2);
        n_vec++; if (n_commit - c0 !== 1 || last_addr !== 7'h06 || last_data !== 9'h07F) begin n_err++; $display("FAIL extra_commit: got n=%0d %h/%h want 1 06/07f", n_commit - c0, last_addr, last_data); end
        send_byte(8'hAA, a3); i2c_stop();
        n_vec++; if ({a0, a1, a2, a3} !== 4'b1110) begin n_err++; $display("FAIL extra_acks: got %b want 1110", {a0, a1, a2, a3}); end
        n_vec++; if (n_nack - k0 !== 1 || n_commit - c0 !== 1) begin n_err++; $display("FAIL extra_nack: got nack=%0d commits=%0d want 1/1", n_nack - k0, n_commit - c0); end
    endtask

    task automatic test_glitch();
        int b0;
        b0 = n_busy;
        sda_m = 1'b0; #20;
        sda_m = 1'b1; #Q;
        n_vec++; if (n_busy - b0 !== 0) begin n_err++; $display("FAIL glitch_start: got busy_cycles=%0d want 0", n_busy - b0); end
    endtask

    task automatic test_reset_mid();
        logic a;
        int c0;
        c0 = n_commit;
        i2c_start(); send_byte(8'h34, a); send_byte(8'h08, a);
        send_bits(8'h12);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #(Q/2);
        n_vec++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL mid_ack_drive: got %b want 1", sda_oe); end
        rst = 1'b1; #1;
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL mid_async_release: got %b want 0", sda_oe); end
        #(Q/2 - 1);
        scl_m = 1'b0; #50;
        rst = 1'b0; #(Q - 50);
        n_vec++; if (bus_busy !== 1'b0 || sda_oe !== 1'b0) begin n_err++; $display("FAIL mid_idle: got busy=%b oe=%b want 0/0", bus_busy, sda_oe); end
        i2c_stop();
        n_vec++; if (n_commit - c0 !== 0) begin n_err++; $display("FAIL mid_commits: got %0d want 0", n_commit - c0); end
        for (int i = 0; i < 10; i++) begin
            cfg_rd_addr = 4'(i); #1;
            n_vec++;
            if (cfg_rd_data !== exp_def[i]) begin n_err++; $display("FAIL mid_shadow[%0d]: got %h want %h", i, cfg_rd_data, exp_def[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_r4();
        test_codec_reset();
        test_addr_filter();
        test_abort();
        test_extra_byte();
        test_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
